// File: rtl/spi_target_sync.sv
// spi_target_sync
// Clock-synchronous SPI target (mode 0, CPOL=0/CPHA=0, LSB first). The SPI pins
// are oversampled in the clk domain, so no logic runs on sclk; clk must be at
// least 4x the sclk frequency.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   sclk, cs, mosi      SPI pins from the master (cs active low)
//   miso, miso_oe       return data and its output enable
//   rx_data/valid/ready received word, valid/ready handshake
//   tx_data/valid/ready word for the next frame, loaded into a holding register
//   frame_err           1-clk pulse: cs rose before DATA_W bits were seen
//   overrun             1-clk pulse: completed word dropped, rx_valid still set
//   underrun            1-clk pulse: frame started with the holding register empty
module spi_target_sync #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    // Input synchronisers plus one history flop for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, cs_prev_q;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              deliver_q, deliver_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;
    logic              miso_oe_q, miso_oe_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // Frame FSM, shift registers, tx holding register and rx delivery
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        deliver_d   = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        underrun_d  = 1'b0;
        miso_oe_d   = miso_oe_q;

        // Loads only into an empty register, so it never collides with the
        // frame-start consume below.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    miso_oe_d = 1'b1;
                    if (hold_full_q) begin
                        tx_sh_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        tx_sh_d    = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // cs rise has priority over a coincident sclk rise.
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    miso_oe_d   = 1'b0;
                end else begin
                    if (sclk_fall) begin
                        tx_sh_d = tx_sh_q >> 1;
                    end
                    if (sclk_rise) begin
                        rx_sh_d   = {mosi_s, rx_sh_q[DATA_W-1:1]};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d   = WAIT_END;
                            deliver_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_END: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake in the delivery cycle frees the slot for the new word.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_sh_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Control state. The synchronised cs resets low so that a high cs pin
    // produces a rise event and leaves the reset WAIT_END state, while a low
    // cs pin (frame in progress) is ignored until it genuinely rises.
    // miso_oe resets low and is only raised by a frame start, so a partial
    // frame seen at reset release is never driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= WAIT_END;
            bit_cnt_q   <= '0;
            hold_full_q <= 1'b0;
            deliver_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_full_q <= hold_full_d;
            deliver_q   <= deliver_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    // Datapath registers; their contents only matter once qualified by control.
    always_ff @(posedge clk) begin
        mosi_sync_q <= mosi_sync_d;
        rx_sh_q     <= rx_sh_d;
        tx_sh_q     <= tx_sh_d;
        hold_q      <= hold_d;
    end

    assign miso      = (state_q == ACTIVE) ? tx_sh_q[0] : 1'b0;
    assign miso_oe   = miso_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_ready  = ~hold_full_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_target_sync.sv
module tb_spi_target_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, cs, mosi;
    logic        miso, miso_oe;
    logic [11:0] rx_data;
    logic        rx_valid, rx_ready;
    logic [11:0] tx_data;
    logic        tx_valid, tx_ready;
    logic        frame_err, overrun, underrun;

    always #5 clk = ~clk;

    spi_target_sync #(.DATA_W(12), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_err(frame_err), .overrun(overrun), .underrun(underrun)
    );

    int total = 0;
    int bad   = 0;

    // Event monitors sampled on the inactive edge
    int          rv_rises = 0, ferr_cnt = 0, ovr_cnt = 0, unr_cnt = 0;
    logic        rv_prev = 1'b0;
    logic [11:0] last_rx = '0;

    always @(negedge clk) begin
        if (rx_valid && !rv_prev) rv_rises++;
        if (rx_valid) last_rx = rx_data;
        rv_prev = rx_valid;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (underrun) unr_cnt++;
    end

    // Values seen by the master at each sclk rise
    logic [11:0] miso_bits;
    logic        txr_at_first, oe_at_first;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [11:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    // One frame, 22-clk sclk period; stops after nbits bits; pulses rst for one
    // clk after bit rst_after (0 = never).
    task automatic send_frame(input logic [11:0] w, input int nbits, input int rst_after);
        miso_bits = '0;
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[i];
            wait_clk(11);
            miso_bits[i] = miso;
            if (i == 0) begin
                txr_at_first = tx_ready;
                oe_at_first  = miso_oe;
            end
            sclk = 1'b1;
            wait_clk(11);
            sclk = 1'b0;
            if (i + 1 == rst_after) begin
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
            end
        end
        mosi = 1'b0;
        wait_clk(11);
        cs = 1'b1;
        wait_clk(22);
    endtask

    task automatic test_reset;
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0;
        wait_clk(3);
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", miso); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
        total++; if (rx_data !== 12'h000) begin bad++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        total++; if ({frame_err, overrun, underrun} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {frame_err, overrun, underrun}); end
        rst = 1'b0;
        wait_clk(8);
        total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL reset_release_ferr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_clean_rx;
        int rv0, fe0, ov0, un0;
        rv0 = rv_rises; fe0 = ferr_cnt; ov0 = ovr_cnt; un0 = unr_cnt;
        preload(12'h5A5);
        send_frame(12'hA5C, 12, 0);
        total++; if (rv_rises - rv0 !== 1) begin bad++; $display("FAIL t1_valid_count: got %0d want 1", rv_rises - rv0); end
        total++; if (last_rx !== 12'hA5C) begin bad++; $display("FAIL t1_rx_data: got %h want a5c", last_rx); end
        total++; if ((ferr_cnt - fe0) + (ovr_cnt - ov0) + (unr_cnt - un0) !== 0) begin
            bad++; $display("FAIL t1_error_pulses: got %0d want 0", (ferr_cnt - fe0) + (ovr_cnt - ov0) + (unr_cnt - un0)); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL t1_valid_cleared: got %b want 0", rx_valid); end
    endtask

    task automatic test_tx;
        logic [11:0] exp_w;
        int un0;
        exp_w = 12'h3C1;
        un0 = unr_cnt;
        preload(exp_w);
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL t2_tx_ready_full: got %b want 0", tx_ready); end
        send_frame(12'h000, 12, 0);
        total++; if (txr_at_first !== 1'b1) begin bad++; $display("FAIL t2_tx_ready_frame: got %b want 1", txr_at_first); end
        total++; if (oe_at_first !== 1'b1) begin bad++; $display("FAIL t2_miso_oe: got %b want 1", oe_at_first); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (miso_bits[i] !== exp_w[i]) begin bad++; $display("FAIL t2_miso_bit%0d: got %b want %b", i, miso_bits[i], exp_w[i]); end
        end
        total++; if (unr_cnt - un0 !== 0) begin bad++; $display("FAIL t2_underrun: got %0d want 0", unr_cnt - un0); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL t2_miso_oe_end: got %b want 0", miso_oe); end
        total++; if (last_rx !== 12'h000) begin bad++; $display("FAIL t2_rx_data: got %h want 000", last_rx); end
    endtask

    task automatic test_abort;
        int rv0, fe0;
        rv0 = rv_rises; fe0 = ferr_cnt;
        send_frame(12'hFFF, 5, 0);
        total++; if (ferr_cnt - fe0 !== 1) begin bad++; $display("FAIL t3_frame_err: got %0d want 1", ferr_cnt - fe0); end
        total++; if (rv_rises - rv0 !== 0) begin bad++; $display("FAIL t3_no_valid: got %0d want 0", rv_rises - rv0); end
        send_frame(12'h001, 12, 0);
        total++; if (rv_rises - rv0 !== 1) begin bad++; $display("FAIL t3_next_valid: got %0d want 1", rv_rises - rv0); end
        total++; if (last_rx !== 12'h001) begin bad++; $display("FAIL t3_next_data: got %h want 001", last_rx); end
        total++; if (ferr_cnt - fe0 !== 1) begin bad++; $display("FAIL t3_next_frame_err: got %0d want 1", ferr_cnt - fe0); end
    endtask

    task automatic test_overrun;
        int rv0, ov0;
        rv0 = rv_rises; ov0 = ovr_cnt;
        rx_ready = 1'b0;
        send_frame(12'h111, 12, 0);
        send_frame(12'h222, 12, 0);
        total++; if (rx_data !== 12'h111) begin bad++; $display("FAIL t4_rx_data: got %h want 111", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL t4_valid_held: got %b want 1", rx_valid); end
        total++; if (ovr_cnt - ov0 !== 1) begin bad++; $display("FAIL t4_overrun: got %0d want 1", ovr_cnt - ov0); end
        total++; if (rv_rises - rv0 !== 1) begin bad++; $display("FAIL t4_valid_count: got %0d want 1", rv_rises - rv0); end
        rx_ready = 1'b1;
        wait_clk(2);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL t4_valid_drop: got %b want 0", rx_valid); end
    endtask

    task automatic test_underrun;
        int rv0, un0;
        rv0 = rv_rises; un0 = unr_cnt;
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL t5_tx_ready: got %b want 1", tx_ready); end
        send_frame(12'h6B3, 12, 0);
        total++; if (unr_cnt - un0 !== 1) begin bad++; $display("FAIL t5_underrun: got %0d want 1", unr_cnt - un0); end
        total++; if (miso_bits !== 12'h000) begin bad++; $display("FAIL t5_miso_zero: got %h want 000", miso_bits); end
        total++; if (rv_rises - rv0 !== 1) begin bad++; $display("FAIL t5_valid_count: got %0d want 1", rv_rises - rv0); end
        total++; if (last_rx !== 12'h6B3) begin bad++; $display("FAIL t5_rx_data: got %h want 6b3", last_rx); end
    endtask

    task automatic test_reset_mid_frame;
        int rv0, fe0;
        rv0 = rv_rises; fe0 = ferr_cnt;
        send_frame(12'h0F0, 12, 6);
        total++; if (rv_rises - rv0 !== 0) begin bad++; $display("FAIL t6_no_valid: got %0d want 0", rv_rises - rv0); end
        total++; if (ferr_cnt - fe0 !== 0) begin bad++; $display("FAIL t6_no_frame_err: got %0d want 0", ferr_cnt - fe0); end
        send_frame(12'hFFF, 12, 0);
        total++; if (rv_rises - rv0 !== 1) begin bad++; $display("FAIL t6_next_valid: got %0d want 1", rv_rises - rv0); end
        total++; if (last_rx !== 12'hFFF) begin bad++; $display("FAIL t6_next_data: got %h want fff", last_rx); end
    endtask

    initial begin
        test_reset();
        test_clean_rx();
        test_tx();
        test_abort();
        test_overrun();
        test_underrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
